// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order ROB retirement stage with store handshake and mispredict flush
module commit_unit #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int FLUSH_HOLD = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      head_itype,
  input  logic [XLEN-1:0] head_value,
  input  logic [REGW-1:0] head_dest,
  input  logic [3:0]      head_rob_num,
  input  logic            head_mispred,
  input  logic            head_ready,
  input  logic            rob_empty,
  input  logic            store_done,
  output logic            rob_rd_en,
  output logic            rf_we,
  output logic [REGW-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [3:0]      rf_wtag,
  output logic            store_commit,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     retire_count
);

  localparam int CW = (FLUSH_HOLD < 1) ? 1 : $clog2(FLUSH_HOLD + 1);

  localparam logic [1:0] ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] ITYPE_STORE  = 2'b01;
  localparam logic [1:0] ITYPE_ALU    = 2'b10;
  localparam logic [1:0] ITYPE_LOAD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH_WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] hold;
  logic          can_retire;

  assign can_retire = !rob_empty && head_ready;

  // State register, post-flush hold counter and retirement counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hold         <= '0;
      retire_count <= '0;
    end else begin
      state <= next_state;
      if (flush) begin
        hold <= CW'(FLUSH_HOLD);
      end else if (state == FLUSH_WAIT && hold != '0) begin
        hold <= hold - CW'(1);
      end
      if (rob_rd_en) begin
        retire_count <= retire_count + 32'd1;
      end
    end
  end

  // Next-state and retirement strobes; everything is held low during reset.
  always_comb begin
    next_state   = state;
    rob_rd_en    = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    rf_wtag      = '0;
    store_commit = 1'b0;
    flush        = 1'b0;
    redirect_pc  = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (can_retire) begin
            case (head_itype)
              ITYPE_ALU, ITYPE_LOAD: begin
                rob_rd_en = 1'b1;
                // x0 is hardwired: retire the entry but never write it.
                rf_we     = (head_dest != '0);
                rf_waddr  = head_dest;
                rf_wdata  = head_value;
                rf_wtag   = head_rob_num;
              end
              ITYPE_BRANCH: begin
                rob_rd_en = 1'b1;
                if (head_mispred) begin
                  flush       = 1'b1;
                  redirect_pc = head_value;
                  next_state  = FLUSH_WAIT;
                end
              end
              ITYPE_STORE: begin
                store_commit = 1'b1;
                next_state   = STORE_WAIT;
              end
              default: begin
                next_state = IDLE;
              end
            endcase
          end
        end
        STORE_WAIT: begin
          store_commit = 1'b1;
          if (store_done) begin
            rob_rd_en  = !rob_empty;
            next_state = IDLE;
          end
        end
        FLUSH_WAIT: begin
          if (hold <= CW'(1)) begin
            next_state = IDLE;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

endmodule
